id_queue_decode: RTL and testbench
==================================

# id_queue_decode

Parametrised decode stage for the RISC-V core, sitting between instruction fetch and EX. It buffers fetched instructions in a QDEPTH-entry queue and decodes the queue head against the register file. Operands are resolved through FWD_SRCS forwarding sources, and load-use hazards stall issue. Decoded operands are issued into an ID/EX output register with a valid/ready handshake and branch flush.

## Interface
Parameters:
- XLEN, 32, data/address width
- QDEPTH, 4, instruction queue depth (power of two, ≥2)
- FWD_SRCS, 2, forwarding sources; index 0 = youngest (EX), higher = older

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard queue and output register
- in_valid / in_ready  in / out  1 / 1  fetch handshake
- in_pc / in_inst  in  XLEN / 32  fetched pc and instruction
- rs1_addr / rs2_addr  out  5 / 5  regfile read addresses; queue-head inst[19:15] / inst[24:20], 0 when queue empty
- rs1_data / rs2_data  in  XLEN / XLEN  combinational regfile read data
- fwd_we  in  FWD_SRCS  per-source write enable
- fwd_wd  in  5*FWD_SRCS  per-source destination register
- fwd_data  in  XLEN*FWD_SRCS  per-source result
- fwd_is_load  in  FWD_SRCS  result not yet available (load in flight)
- out_valid / out_ready  out / in  1 / 1  EX handshake
- out_alusel  out  6  {class[2:0], funct3}
- out_alt  out  1  inst[30] for OP, and for OP-IMM with funct3=101; else 0
- out_opr1 / out_opr2 / out_imm / out_pc  out  XLEN  operands
- out_wd  out  5  destination register
- out_wreg  out  1  register write enable
- out_illegal  out  1  unrecognised opcode

## Operation
- Queue: circular buffer with wr_ptr/rd_ptr of log2(QDEPTH)+1 bits. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
  - in_ready = !full.
  - Push on in_valid & in_ready & !flush.
- Decode of the head (combinational). Classes:
  - 000 OP-IMM: reads rs1; I-imm.
  - 001 OP: reads rs1, rs2.
  - 010 misc, with funct3 field fixed: LUI 000 (U-imm), AUIPC 001 (U-imm), JAL 010 (J-imm), JALR 011 (reads rs1; I-imm).
  - 011 BRANCH: reads rs1, rs2; B-imm.
  - 100 LOAD: reads rs1; I-imm.
  - 101 STORE: reads rs1, rs2; S-imm.
  - Other opcode: alusel=0, illegal=1, wreg=0, no reads.
- Immediates are sign-extended to XLEN. The U-imm low 12 bits are zero.
- wreg=1 for OP-IMM, OP, misc and LOAD, forced to 0 when rd=0. out_wd = inst[11:7].
- Operand resolution, per source with a read enable:
  - Address 0 resolves to 0.
  - Otherwise the lowest index i with fwd_we[i] & fwd_wd[i]==addr supplies fwd_data[i].
  - Otherwise rs*_data.
- Operand assignment:
  - out_opr1 = rs1 value, or 0 if rs1 is not read.
  - out_opr2 = rs2 value if rs2 is read, else the immediate.
  - out_imm = immediate.
  - out_pc = head pc.
- Hazard: the head stalls when a read source's selected forwarding match (the lowest matching index) has fwd_is_load=1. A non-zero address is required for this.
- Issue: issue = head present & !hazard & (!out_valid | out_ready) & !flush.
  - On issue, the output register loads the decode, out_valid←1, and rd_ptr advances.
  - Else if out_ready, out_valid←0.
  - Output fields hold when not loaded.
- Flush: at the edge, rd_ptr←wr_ptr, out_valid←0. A same-cycle input is dropped (not pushed).
- Reset: pointers 0, out_valid 0, all out_* registers 0. rs*_addr read 0 because the queue is empty. in_ready=1 the cycle after reset.

## Timing
- Minimum latency: instruction accepted at edge N → out_valid=1 after edge N+1. There is no bypass of an empty queue.
- Throughput: 1 instr/cycle with out_ready held high.
- Push and pop in the same cycle are legal at any occupancy except full, where no push occurs.
- A stall holds the head, the queue and the output register. out_valid falls after a consumed beat if nothing is issued.
- flush has priority over push, issue and rst-free state. rst has priority over flush.
- fwd_* inputs are sampled combinationally in the issue cycle. A hazard clears in the cycle fwd_is_load drops.

## Test plan
- Reset, then push ADDI x1,x0,5 (0x00500093) at pc 0x100 → two edges later: out_valid=1, alusel=000000, opr1=0, opr2=5, wd=1, wreg=1, pc=0x100.
- ADD x3,x1,x2 with fwd0 {we=1, wd=1, data=7} and fwd1 {we=1, wd=1, data=9}, rs2_data=4 → opr1=7 (index 0 wins), opr2=4.
- Load-use: head ADD x3,x1,x2 with fwd0 {we=1, wd=1, is_load=1} for 2 cycles → out_valid stays 0 and rd_ptr holds; issue on the cycle after is_load=0.
- Hold out_ready=0 and push 5 instructions with QDEPTH=4 → in_ready=0 once 4 are queued (1 held in the output reg); drain in order with no loss or duplication.
- Flush with 3 queued and out_valid=1, in_valid=1 the same cycle → next cycle out_valid=0, queue empty, dropped input absent.
- LUI x0,0x12345 → wreg=0, imm=0x12345000. Opcode 0x7F → illegal=1, alusel=0. SUB x5,x6,x7 → alt=1.

Source files
------------

// File: rtl/id_queue_decode.sv
// id_queue_decode: instruction queue plus head decode, operand forwarding and load-use stall, feeding an ID/EX register.
module id_queue_decode #(
  parameter int XLEN = 32,
  parameter int QDEPTH = 4,
  parameter int FWD_SRCS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  output logic [4:0]               rs1_addr,
  output logic [4:0]               rs2_addr,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          rs2_data,
  input  logic [FWD_SRCS-1:0]      fwd_we,
  input  logic [5*FWD_SRCS-1:0]    fwd_wd,
  input  logic [XLEN*FWD_SRCS-1:0] fwd_data,
  input  logic [FWD_SRCS-1:0]      fwd_is_load,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_alusel,
  output logic                     out_alt,
  output logic [XLEN-1:0]          out_opr1,
  output logic [XLEN-1:0]          out_opr2,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_wd,
  output logic                     out_wreg,
  output logic                     out_illegal
);
  localparam int AW = $clog2(QDEPTH);
  logic [XLEN-1:0] pc_q [QDEPTH];
  logic [31:0] inst_q [QDEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, push, issue, hazard;
  logic [31:0] inst, imm32;
  logic [2:0] cls, f3o;
  logic legal, rd1, rd2, wreg, alt, haz1, haz2;
  logic [XLEN-1:0] imm, v1, v2;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign in_ready = !full;
  assign push = in_valid && !full && !flush;
  // An empty queue presents opcode 0: illegal, no reads, register addresses 0.
  assign inst = empty ? 32'h0 : inst_q[rd_ptr[AW-1:0]];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign imm = XLEN'($signed(imm32));
  always_comb begin
    cls = 3'd0;
    f3o = inst[14:12];
    legal = 1'b1;
    rd1 = 1'b0;
    rd2 = 1'b0;
    wreg = 1'b0;
    alt = 1'b0;
    imm32 = '0;
    case (inst[6:0])
      7'b0010011: begin rd1 = 1'b1; wreg = 1'b1; alt = inst[14:12] == 3'b101 && inst[30]; imm32 = {{20{inst[31]}}, inst[31:20]}; end
      7'b0110011: begin cls = 3'd1; rd1 = 1'b1; rd2 = 1'b1; wreg = 1'b1; alt = inst[30]; end
      7'b0110111: begin cls = 3'd2; f3o = 3'd0; wreg = 1'b1; imm32 = {inst[31:12], 12'h0}; end
      7'b0010111: begin cls = 3'd2; f3o = 3'd1; wreg = 1'b1; imm32 = {inst[31:12], 12'h0}; end
      7'b1101111: begin cls = 3'd2; f3o = 3'd2; wreg = 1'b1; imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; end
      7'b1100111: begin cls = 3'd2; f3o = 3'd3; rd1 = 1'b1; wreg = 1'b1; imm32 = {{20{inst[31]}}, inst[31:20]}; end
      7'b1100011: begin cls = 3'd3; rd1 = 1'b1; rd2 = 1'b1; imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; end
      7'b0000011: begin cls = 3'd4; rd1 = 1'b1; wreg = 1'b1; imm32 = {{20{inst[31]}}, inst[31:20]}; end
      7'b0100011: begin cls = 3'd5; rd1 = 1'b1; rd2 = 1'b1; imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]}; end
      default: legal = 1'b0;
    endcase
  end
  // Walk oldest to youngest so the lowest matching index has the final say.
  always_comb begin
    v1 = rs1_data;
    v2 = rs2_data;
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int i = FWD_SRCS-1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_wd[5*i +: 5] == rs1_addr) begin v1 = fwd_data[XLEN*i +: XLEN]; haz1 = fwd_is_load[i]; end
      if (fwd_we[i] && fwd_wd[5*i +: 5] == rs2_addr) begin v2 = fwd_data[XLEN*i +: XLEN]; haz2 = fwd_is_load[i]; end
    end
    if (rs1_addr == 5'd0) begin v1 = '0; haz1 = 1'b0; end
    if (rs2_addr == 5'd0) begin v2 = '0; haz2 = 1'b0; end
  end
  assign hazard = (rd1 && haz1) || (rd2 && haz2);
  assign issue = !empty && !hazard && (!out_valid || out_ready) && !flush;
  always_ff @(posedge clk)
    if (push) begin
      pc_q[wr_ptr[AW-1:0]] <= in_pc;
      inst_q[wr_ptr[AW-1:0]] <= in_inst;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_valid <= 1'b0;
      out_alusel <= '0;
      out_alt <= 1'b0;
      out_opr1 <= '0;
      out_opr2 <= '0;
      out_imm <= '0;
      out_pc <= '0;
      out_wd <= '0;
      out_wreg <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (issue) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        out_valid <= 1'b1;
        out_alusel <= legal ? {cls, f3o} : 6'd0;
        out_alt <= alt;
        out_opr1 <= rd1 ? v1 : '0;
        out_opr2 <= rd2 ? v2 : imm;
        out_imm <= imm;
        out_pc <= pc_q[rd_ptr[AW-1:0]];
        out_wd <= inst[11:7];
        out_wreg <= wreg && inst[11:7] != 5'd0;
        out_illegal <= !legal;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_queue_decode.sv
// tb_id_queue_decode: randomized and directed checks of id_queue_decode against a queue-based behavioural model.
module tb_id_queue_decode;
  localparam int XLEN = 32, QDEPTH = 4, FWD_SRCS = 2;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_alt, out_wreg, out_illegal;
  logic [31:0] in_pc = '0, in_inst = '0, rs1_data = '0, rs2_data = '0;
  logic [31:0] out_opr1, out_opr2, out_imm, out_pc;
  logic [4:0] rs1_addr, rs2_addr, out_wd;
  logic [5:0] out_alusel;
  logic [FWD_SRCS-1:0] fwd_we = '0, fwd_is_load = '0;
  logic [5*FWD_SRCS-1:0] fwd_wd = '0;
  logic [XLEN*FWD_SRCS-1:0] fwd_data = '0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  id_queue_decode #(.XLEN(XLEN), .QDEPTH(QDEPTH), .FWD_SRCS(FWD_SRCS)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_we(fwd_we), .fwd_wd(fwd_wd),
    .fwd_data(fwd_data), .fwd_is_load(fwd_is_load), .out_valid(out_valid), .out_ready(out_ready),
    .out_alusel(out_alusel), .out_alt(out_alt), .out_opr1(out_opr1), .out_opr2(out_opr2),
    .out_imm(out_imm), .out_pc(out_pc), .out_wd(out_wd), .out_wreg(out_wreg), .out_illegal(out_illegal));
  typedef struct packed {
    logic valid;
    logic [5:0] alusel;
    logic alt;
    logic [31:0] opr1, opr2, imm, pc;
    logic [4:0] wd;
    logic wreg, illegal;
  } ex_t;
  typedef struct packed {logic [31:0] pc, inst;} ent_t;
  ent_t q[$];
  ex_t m;
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [31:0] sx(int bits, logic [31:0] v);
    return 32'($signed(v << (32 - bits)) >>> (32 - bits));
  endfunction
  function automatic void resolve(logic [4:0] a, logic [31:0] rf, output logic [31:0] v, output logic ld);
    v = rf;
    ld = 0;
    if (a == 0) begin v = 0; return; end
    for (int i = 0; i < FWD_SRCS; i++)
      if (fwd_we[i] && fwd_wd[5*i +: 5] == a) begin v = fwd_data[32*i +: 32]; ld = fwd_is_load[i]; return; end
  endfunction
  function automatic ex_t predict(ent_t e, output logic haz);
    logic [31:0] i;
    logic [2:0] f3;
    logic r1, r2, la, lb;
    logic [31:0] a, b;
    ex_t x;
    i = e.inst; f3 = i[14:12]; r1 = 0; r2 = 0; x = '0;
    x.valid = 1; x.pc = e.pc; x.wd = i[11:7];
    case (i[6:0])
      7'h13: begin x.alusel = {3'd0, f3}; r1 = 1; x.wreg = 1; x.imm = sx(12, i >> 20); x.alt = f3 == 3'd5 && i[30]; end
      7'h33: begin x.alusel = {3'd1, f3}; r1 = 1; r2 = 1; x.wreg = 1; x.alt = i[30]; end
      7'h37: begin x.alusel = 6'o20; x.wreg = 1; x.imm = i & 32'hFFFFF000; end
      7'h17: begin x.alusel = 6'o21; x.wreg = 1; x.imm = i & 32'hFFFFF000; end
      7'h6F: begin x.alusel = 6'o22; x.wreg = 1; x.imm = sx(21, {i[31], i[19:12], i[20], i[30:21], 1'b0}); end
      7'h67: begin x.alusel = 6'o23; r1 = 1; x.wreg = 1; x.imm = sx(12, i >> 20); end
      7'h63: begin x.alusel = {3'd3, f3}; r1 = 1; r2 = 1; x.imm = sx(13, {i[31], i[7], i[30:25], i[11:8], 1'b0}); end
      7'h03: begin x.alusel = {3'd4, f3}; r1 = 1; x.wreg = 1; x.imm = sx(12, i >> 20); end
      7'h23: begin x.alusel = {3'd5, f3}; r1 = 1; r2 = 1; x.imm = sx(12, {i[31:25], i[11:7]}); end
      default: x.illegal = 1;
    endcase
    if (x.wd == 0) x.wreg = 0;
    resolve(i[19:15], rs1_data, a, la);
    resolve(i[24:20], rs2_data, b, lb);
    x.opr1 = r1 ? a : 0;
    x.opr2 = r2 ? b : x.imm;
    haz = (r1 && la) || (r2 && lb);
    return x;
  endfunction
  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 9))
      0: i[6:0] = 7'h13; 1: i[6:0] = 7'h33; 2: i[6:0] = 7'h37; 3: i[6:0] = 7'h17; 4: i[6:0] = 7'h6F;
      5: i[6:0] = 7'h67; 6: i[6:0] = 7'h63; 7: i[6:0] = 7'h03; 8: i[6:0] = 7'h23; default: i[6:0] = 7'h7F;
    endcase
    i[11:7] = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction
  // Check the current registered state, then advance the model by one clock using the driven inputs.
  task automatic step();
    ex_t nx;
    logic haz, pres, full, iss;
    #1;
    pres = q.size() > 0;
    full = q.size() == QDEPTH;
    chk("in_ready", in_ready, !full);
    chk("rs1_addr", rs1_addr, pres ? q[0].inst[19:15] : 5'd0);
    chk("rs2_addr", rs2_addr, pres ? q[0].inst[24:20] : 5'd0);
    chk("out_valid", out_valid, m.valid);
    chk("out_alusel", out_alusel, m.alusel);
    chk("out_alt", out_alt, m.alt);
    chk("out_opr1", out_opr1, m.opr1);
    chk("out_opr2", out_opr2, m.opr2);
    chk("out_imm", out_imm, m.imm);
    chk("out_pc", out_pc, m.pc);
    chk("out_wd", out_wd, m.wd);
    chk("out_wreg", out_wreg, m.wreg);
    chk("out_illegal", out_illegal, m.illegal);
    if (rst) begin q.delete(); m = '0; end
    else if (flush) begin q.delete(); m.valid = 0; end
    else begin
      haz = 1;
      nx = '0;
      if (pres) nx = predict(q[0], haz);
      iss = pres && !haz && (!m.valid || out_ready);
      if (iss) begin m = nx; void'(q.pop_front()); end
      else if (out_ready) m.valid = 0;
      if (in_valid && !full) q.push_back({in_pc, in_inst});
    end
    @(negedge clk);
  endtask
  task automatic push(logic [31:0] pc, logic [31:0] inst);
    in_valid = 1; in_pc = pc; in_inst = inst;
    step();
    in_valid = 0;
  endtask
  initial begin
    m = '0;
    repeat (2) @(negedge clk);
    step();
    rst = 0;
    chk("lit reset out_valid", out_valid, 0);
    chk("lit reset in_ready", in_ready, 1);
    push(32'h100, 32'h00500093);
    step();
    chk("lit addi out_valid", out_valid, 1);
    chk("lit addi alusel", out_alusel, 0);
    chk("lit addi opr1", out_opr1, 0);
    chk("lit addi opr2", out_opr2, 5);
    chk("lit addi wd", out_wd, 1);
    chk("lit addi wreg", out_wreg, 1);
    chk("lit addi pc", out_pc, 32'h100);
    step();
    push(32'h104, 32'h002081B3);
    fwd_we = 2'b11; fwd_wd = {5'd1, 5'd1}; fwd_data = {32'd9, 32'd7}; rs2_data = 4;
    step();
    chk("lit fwd opr1", out_opr1, 7);
    chk("lit fwd opr2", out_opr2, 4);
    fwd_we = 0;
    step();
    push(32'h108, 32'h002081B3);
    fwd_we = 2'b01; fwd_wd = {5'd0, 5'd1}; fwd_is_load = 2'b01;
    repeat (2) step();
    chk("lit loaduse out_valid", out_valid, 0);
    chk("lit loaduse rs1_addr held", rs1_addr, 1);
    fwd_is_load = 0;
    step();
    chk("lit loaduse issue", out_valid, 1);
    fwd_we = 0;
    step();
    out_ready = 0;
    for (int k = 0; k < 5; k++) push(32'h200 + 4 * k, rand_inst());
    chk("lit full in_ready", in_ready, 0);
    out_ready = 1;
    step();
    chk("lit drain pc", out_pc, 32'h204);
    repeat (5) step();
    out_ready = 0;
    for (int k = 0; k < 4; k++) push(32'h300 + 4 * k, rand_inst());
    chk("lit preflush out_valid", out_valid, 1);
    flush = 1;
    push(32'h3F0, rand_inst());
    flush = 0;
    chk("lit flush out_valid", out_valid, 0);
    chk("lit flush in_ready", in_ready, 1);
    out_ready = 1;
    step();
    chk("lit flush dropped", out_valid, 0);
    push(32'h400, 32'h12345037);
    push(32'h404, 32'h0000007F);
    chk("lit lui wreg", out_wreg, 0);
    chk("lit lui imm", out_imm, 32'h12345000);
    push(32'h408, 32'h407302B3);
    chk("lit illegal", out_illegal, 1);
    chk("lit illegal alusel", out_alusel, 0);
    step();
    chk("lit sub alt", out_alt, 1);
    for (int c = 0; c < 3000; c++) begin
      rst = c == 1500;
      flush = $urandom_range(0, 19) == 0;
      in_valid = $urandom_range(0, 1) == 1;
      in_pc = $urandom;
      in_inst = rand_inst();
      out_ready = $urandom_range(0, 3) != 0;
      rs1_data = $urandom;
      rs2_data = $urandom;
      fwd_we = FWD_SRCS'($urandom);
      for (int i = 0; i < FWD_SRCS; i++) begin
        fwd_wd[5*i +: 5] = 5'($urandom_range(0, 3));
        fwd_data[32*i +: 32] = $urandom;
        fwd_is_load[i] = $urandom_range(0, 3) == 0;
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
